ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_edge_filter.sv | 60 ++++++
 rtl/ps2_host_tx.sv | 211 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 host-transmit definitions: FSM state encoding, frame length and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RTS      = 3'd1,
    ST_START    = 3'd2,
    ST_DATA     = 3'd3,
    ST_PAR      = 3'd4,
    ST_STOP     = 3'd5,
    ST_ACK      = 3'd6,
    ST_WAIT_REL = 3'd7
  } ps2_state_e;

  // start + 8 data + parity + stop; the device clocks one falling edge per bit
  localparam int unsigned FRAME_BITS = 11;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// Two-flop synchroniser with optional run-length glitch filter; emits a one-cycle
// event when the filtered level goes 1->0. FILTER_EN=0 gives a plain synchronised level.
module ps2_edge_filter #(
  parameter int unsigned FILTER_LEN = 8,
  parameter bit          FILTER_EN  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CNT_W = $clog2(FILTER_LEN + 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fall_q, fall_d;

  // Next-state: the level flips only after FILTER_LEN consecutive differing samples.
  always_comb begin
    sync_d  = {sync_q[0], line_i};
    level_d = level_q;
    cnt_d   = cnt_q;
    if (FILTER_EN) begin
      if (sync_q[1] == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        level_d = sync_q[1];
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end
    fall_d = level_q & ~level_d;
  end

  // State registers; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter (open-collector clock/data).
// Define PS2_TX_TIMEOUT_EN to abort a frame when the device stops clocking.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC = 5000,
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       ack_err
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ps2_state_e       state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic [3:0]       nfall_q, nfall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             c_oe_q, c_oe_d;
  logic             d_oe_q, d_oe_d;
  logic             nack_q, nack_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             idle_q, idle_d;

  logic             ps2c_f_s, fall_s;
  logic             ps2d_s, ps2d_fall_unused;
  logic             tmo_arm_s, tmo_hit_s;
  logic [CNT_W-1:0] tmo_inc_s;

  ps2_edge_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b1)) u_clk_filt (
    .clk     (clk),
    .reset   (reset),
    .line_i  (ps2c),
    .level_o (ps2c_f_s),
    .fall_o  (fall_s)
  );

  ps2_edge_filter #(.FILTER_LEN(FILTER_LEN), .FILTER_EN(1'b0)) u_dat_sync (
    .clk     (clk),
    .reset   (reset),
    .line_i  (ps2d),
    .level_o (ps2d_s),
    .fall_o  (ps2d_fall_unused)
  );

  assign tmo_arm_s = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_PAR) ||
                     (state_q == ST_STOP)  || (state_q == ST_ACK);

`ifdef PS2_TX_TIMEOUT_EN
  assign tmo_inc_s = cnt_q + CNT_W'(1);
  assign tmo_hit_s = tmo_arm_s & ~fall_s & (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_inc_s = cnt_q;
  assign tmo_hit_s = 1'b0;
`endif

  // Frame sequencer: falls 1..8 present data, 9 parity, 10 releases (stop), 11 carries the ack.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    nfall_d = nfall_q;
    cnt_d   = cnt_q;
    c_oe_d  = c_oe_q;
    d_oe_d  = d_oe_q;
    nack_d  = nack_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        c_oe_d = 1'b0;
        d_oe_d = 1'b0;
        if (wr_ps2) begin
          data_d  = din;
          cnt_d   = '0;
          nfall_d = 4'd0;
          nack_d  = 1'b0;
          c_oe_d  = 1'b1;
          state_d = ST_RTS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RTS: begin
        if (cnt_q == CNT_W'(INHIBIT_CYC - 1)) begin
          c_oe_d  = 1'b0;
          d_oe_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_START;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_START: begin
        if (fall_s) begin
          nfall_d = 4'd1;
          d_oe_d  = ~data_q[0];
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (fall_s) begin
          nfall_d = nfall_q + 4'd1;
          if (nfall_q == 4'd8) begin
            d_oe_d  = ~odd_parity(data_q);
            state_d = ST_PAR;
          end else begin
            d_oe_d = ~data_q[nfall_q[2:0]];
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PAR: begin
        if (fall_s) begin
          nfall_d = nfall_q + 4'd1;
          d_oe_d  = 1'b0;
          state_d = ST_STOP;
        end else begin
          state_d = ST_PAR;
        end
      end
      // STOP marks the released stop slot; the device answers during it
      ST_STOP: begin
        state_d = ST_ACK;
      end
      ST_ACK: begin
        if (fall_s && (nfall_q == 4'(FRAME_BITS - 1))) begin
          nfall_d = 4'(FRAME_BITS);
          nack_d  = ps2d_s;
          state_d = ST_WAIT_REL;
        end else begin
          state_d = ST_ACK;
        end
      end
      ST_WAIT_REL: begin
        if (ps2c_f_s && ps2d_s) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_REL;
        end
      end
      default: begin
        c_oe_d  = 1'b0;
        d_oe_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (tmo_hit_s) begin
      c_oe_d  = 1'b0;
      d_oe_d  = 1'b0;
      cnt_d   = '0;
      done_d  = 1'b1;
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else if (tmo_arm_s) begin
      cnt_d = fall_s ? '0 : tmo_inc_s;
    end else begin
      err_d = done_d & nack_q;
    end

    idle_d = (state_d == ST_IDLE);
  end

  // Single state/output register bank; reset releases both lines at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= 8'h00;
      nfall_q <= 4'd0;
      cnt_q   <= '0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      nack_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      nfall_q <= nfall_d;
      cnt_q   <= cnt_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      nack_q  <= nack_d;
      done_q  <= done_d;
      err_q   <= err_d;
      idle_q  <= idle_d;
    end
  end

  assign ps2c         = c_oe_q ? 1'b0 : 1'bz;
  assign ps2d         = d_oe_q ? 1'b0 : 1'bz;
  assign tx_idle      = idle_q;
  assign tx_done_tick = done_q;
  assign ack_err      = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks frames, a monitor checks each done pulse.
`timescale 1ns/1ps
module tb_ps2_host_tx;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TMO = 3000;
`else
  localparam int unsigned TMO = 750000;
`endif
  localparam int HALF = 40;

  typedef struct packed {
    logic [10:0] frame;
    logic        err;
    logic        chk_frame;
  } exp_t;

  typedef struct packed {
    logic [7:0]  d;
    logic [10:0] frame;
    logic        ack;
    logic [3:0]  poke;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_ps2;
  logic [7:0] din;
  logic       tx_idle, tx_done_tick, ack_err;
  logic       dev_c_low, dev_d_low;
  wire        ps2c, ps2d;

  exp_t        exp_q[$];
  logic [10:0] cap_frame;
  int          total = 0;
  int          bad = 0;
  int          done_cnt = 0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYC(5000), .FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_ps2       (wr_ps2),
    .din          (din),
    .ps2c         (ps2c),
    .ps2d         (ps2d),
    .tx_idle      (tx_idle),
    .tx_done_tick (tx_done_tick),
    .ack_err      (ack_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [7:0] v);
    @(negedge clk);
    din    = v;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // Device side: measure the inhibit, then clock nfalls bits, recording the line before each rise.
  task automatic dev_frame(input int nfalls, input bit do_ack, input int poke,
                           input logic [7:0] orig, output int low_cyc);
    int t;
    t = 0;
    while (ps2c !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    low_cyc = 0;
    while (ps2c === 1'b0 && low_cyc < 20000) begin
      low_cyc++;
      @(negedge clk);
    end
    repeat (50) @(negedge clk);
    cap_frame    = 11'd0;
    cap_frame[0] = ps2d;
    for (int k = 1; k <= nfalls; k++) begin
      dev_c_low = 1'b1;
      if (k == poke) begin
        repeat (4) @(negedge clk);
        din    = 8'hAA;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        din    = orig;
        repeat (HALF - 5) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      if (k <= 10) cap_frame[k] = ps2d;
      dev_c_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
      if (k == 10 && do_ack) dev_d_low = 1'b1;
      if (k == 11) dev_d_low = 1'b0;
      repeat (HALF / 2) @(negedge clk);
    end
  endtask

  task automatic drain(input string name, input int bound);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < bound) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL %s: no done pulse, %0d expected pending", name, exp_q.size());
      exp_q.delete();
    end else begin
      repeat (2) @(negedge clk);
      chk({name, " tx_idle"}, 32'(tx_idle), 32'd1);
    end
  endtask

  // Monitor: every done pulse pops one expectation; stray pulses are errors.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && tx_done_tick === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL stray_done: got tx_done_tick=1 expected none");
        end else begin
          e = exp_q.pop_front();
          chk("ack_err", 32'(ack_err), 32'(e.err));
          if (e.chk_frame) chk("frame", 32'(cap_frame), 32'(e.frame));
        end
      end else if (!reset && ack_err === 1'b1) begin
        total++;
        bad++;
        $display("FAIL lone_ack_err: got ack_err=1 without tx_done_tick");
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vecs[6];
    int   low;
    int   dc;
    vecs[0] = '{8'hF4, 11'h5E8, 1'b1, 4'd0};
    vecs[1] = '{8'hFF, 11'h7FE, 1'b1, 4'd0};
    vecs[2] = '{8'h00, 11'h600, 1'b1, 4'd0};
    vecs[3] = '{8'h01, 11'h402, 1'b1, 4'd0};
    vecs[4] = '{8'h3C, 11'h678, 1'b0, 4'd0};
    vecs[5] = '{8'h5A, 11'h6B4, 1'b1, 4'd3};

    reset = 1'b1; wr_ps2 = 1'b0; din = 8'h00; dev_c_low = 1'b0; dev_d_low = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst tx_idle", 32'(tx_idle), 32'd1);
    chk("rst done", 32'(tx_done_tick), 32'd0);
    chk("rst ack_err", 32'(ack_err), 32'd0);
    chk("rst ps2c", 32'(ps2c), 32'd1);
    chk("rst ps2d", 32'(ps2d), 32'd1);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      exp_q.push_back('{vecs[i].frame, ~vecs[i].ack, 1'b1});
      issue(vecs[i].d);
      dev_frame(11, vecs[i].ack, int'(vecs[i].poke), vecs[i].d, low);
      chk("inhibit cycles", 32'(low), 32'd5000);
      drain("frame", 2000);
    end

    // Abort by reset after the fifth fall: lines must float back immediately.
    dc = done_cnt;
    issue(8'h00);
    dev_frame(5, 1'b0, 0, 8'h00, low);
    chk("mid ps2d driven", 32'(ps2d), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst ps2c released", 32'(ps2c), 32'd1);
    chk("rst ps2d released", 32'(ps2d), 32'd1);
    chk("rst tx_idle async", 32'(tx_idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("abort no done", 32'(done_cnt), 32'(dc));
    chk("abort tx_idle", 32'(tx_idle), 32'd1);

`ifdef PS2_TX_TIMEOUT_EN
    exp_q.push_back('{11'h000, 1'b1, 1'b0});
    issue(8'h00);
    dev_frame(5, 1'b0, 0, 8'h00, low);
    drain("timeout", TMO + 500);
    chk("timeout ps2d released", 32'(ps2d), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
